paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Game-mode controller that owns the two paddle positions fed to the renderer and collision logic. It sequences between attract (demo) mode, live play and pause. In demo mode it enables and forwards the autonomous demo-paddle generator. In play it moves each paddle from its player's up/down buttons once per frame tick, clamped to the playfield. It drops back to demo after a configurable number of idle frames.

## Interface
- Y_MIN, 62: lowest legal paddle y (top limit).
- Y_MAX, 418: highest legal paddle y (bottom limit).
- STEP, 4: pixels moved per frame tick while a button is held.
- IDLE_FRAMES, 1800: consecutive idle ticks in PLAY before returning to DEMO (30 s at 60 Hz); must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle frame strobe (start of vertical blank).
- start  in  1  start/pause button, level, debounced and synchronous to clk upstream.
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  player buttons, level, debounced and synchronous.
- demo_p1_y, demo_p2_y  in  11  positions from the demo paddle generator.
- demo_en  out  1  enable to the demo generator; high only in DEMO.
- p1_y, p2_y  out  11  registered paddle positions.
- mode  out  2  00 DEMO, 01 PLAY, 10 PAUSE (11 never driven).
- play_start  out  1  one-cycle pulse on DEMO→PLAY, used by the score block to clear scores.

## Operation
- start_press = start & ~start_q, where start_q is start registered each cycle. Only rising edges act; holding start has no further effect.
- States DEMO, PLAY, PAUSE; reset state DEMO.
- DEMO:
  - demo_en=1; p1_y/p2_y load demo_p1_y/demo_p2_y every cycle (one-cycle latency).
  - On start_press: go to PLAY; p1_y/p2_y load the current demo inputs that cycle; idle counter cleared; play_start=1 next cycle.
- PLAY: demo_en=0. On a cycle with tick=1, each paddle updates independently:
  - up only: y = max(y − STEP, Y_MIN).
  - down only: y = min(y + STEP, Y_MAX).
  - both or neither: y unchanged.
  - Arithmetic is done in 12 bits so y − STEP cannot wrap below 0.
- Idle counter (ceil(log2(IDLE_FRAMES))+1 bits), evaluated in PLAY only on tick:
  - any of the four buttons high: clear to 0.
  - otherwise, if count == IDLE_FRAMES−1: go to DEMO.
  - otherwise: increment.
- PAUSE: positions and idle counter frozen; ticks and buttons ignored; start_press → PLAY. PAUSE never times out.
- PLAY + start_press → PAUSE. Pause has priority over a same-cycle tick: no movement and no idle count that cycle.
- DEMO entry after timeout: positions resume tracking the demo inputs from the next cycle. The demo generator keeps its own state while disabled.

## Timing
- Reset values: mode=00, demo_en=1, p1_y=62 (Y_MIN), p2_y=418 (Y_MAX), play_start=0, idle counter 0, start_q=0.
- All outputs are registered. A state change is visible on mode and demo_en one cycle after the triggering start_press or tick.
- Position change appears one cycle after the tick that caused it.
- play_start is high for exactly one cycle, the same cycle mode first reads 01 after DEMO. It is not pulsed on PAUSE→PLAY.
- start_press and tick in the same cycle in DEMO: go to PLAY; no movement that cycle.
- Timeout tick with a button high: counter clears, stay in PLAY.
- rst mid-game: immediate return to reset values regardless of state; a start held through reset release does not produce a press.

## Test plan
- Reset then idle: mode=00, demo_en=1, p1_y=62, p2_y=418. Drive demo_p1_y=200 → p1_y=200 one cycle later.
- Start edge in DEMO with demo inputs 150/330 → mode=01, demo_en=0, p1_y=150, p2_y=330, play_start single pulse. Hold start 10 cycles → no further transitions.
- PLAY, p1_y=64, hold p1_up for 2 ticks → 62 then 62. p2_y=416 with p2_dn → 418. Both p1 buttons held → no change.
- start_press coincident with tick while p1_up held → mode=10, p1_y unchanged. Ticks in PAUSE → frozen. Next start_press → mode=01, no play_start.
- IDLE_FRAMES=4, no buttons: 4th tick → mode=00 next cycle. With p2_dn pulsed at tick 3, return to DEMO occurs only at tick 7.
- Assert rst while in PAUSE with p1_y=300 → outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/paddle_ctrl.sv
// Game-mode controller: sequences DEMO/PLAY/PAUSE and owns both paddle positions.
// All outputs registered; positions and mode change one cycle after the causing tick or start press.
module paddle_ctrl #(
    parameter int Y_MIN       = 62,
    parameter int Y_MAX       = 418,
    parameter int STEP        = 4,
    parameter int IDLE_FRAMES = 1800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    input  logic [10:0] demo_p1_y,
    input  logic [10:0] demo_p2_y,
    output logic        demo_en,
    output logic [10:0] p1_y,
    output logic [10:0] p2_y,
    output logic [1:0]  mode,
    output logic        play_start
);

    localparam int CW = $clog2(IDLE_FRAMES) + 1;

    typedef enum logic [1:0] {
        DEMO  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [10:0]   p1_y_q, p1_y_d, p2_y_q, p2_y_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          play_start_q, play_start_d;
    logic          start_q;
    logic          armed_q;
    logic          start_press;
    logic          any_btn;

    // 12-bit arithmetic so a step below zero cannot wrap before clamping.
    function automatic logic [10:0] move(input logic [10:0] y, input logic up, input logic dn);
        logic [11:0] y12;
        logic [11:0] r;
        y12 = {1'b0, y};
        r   = y12;
        if (up && !dn) begin
            r = (y12 < 12'(Y_MIN + STEP)) ? 12'(Y_MIN) : y12 - 12'(STEP);
        end else if (dn && !up) begin
            r = ((y12 + 12'(STEP)) > 12'(Y_MAX)) ? 12'(Y_MAX) : y12 + 12'(STEP);
        end
        return r[10:0];
    endfunction

    // armed_q blocks a start level held through reset release from counting as a press.
    assign start_press = start & ~start_q & armed_q;
    assign any_btn     = p1_up | p1_dn | p2_up | p2_dn;

    always_comb begin
        state_d      = state_q;
        p1_y_d       = p1_y_q;
        p2_y_d       = p2_y_q;
        idle_d       = idle_q;
        play_start_d = 1'b0;
        case (state_q)
            DEMO: begin
                p1_y_d = demo_p1_y;
                p2_y_d = demo_p2_y;
                if (start_press) begin
                    state_d      = PLAY;
                    idle_d       = '0;
                    play_start_d = 1'b1;
                end
            end
            PLAY: begin
                if (start_press) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    p1_y_d = move(p1_y_q, p1_up, p1_dn);
                    p2_y_d = move(p2_y_q, p2_up, p2_dn);
                    if (any_btn) begin
                        idle_d = '0;
                    end else if (idle_q == CW'(IDLE_FRAMES - 1)) begin
                        state_d = DEMO;
                    end else begin
                        idle_d = idle_q + CW'(1);
                    end
                end
            end
            PAUSE: begin
                if (start_press) begin
                    state_d = PLAY;
                end
            end
            default: state_d = DEMO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DEMO;
            p1_y_q       <= 11'(Y_MIN);
            p2_y_q       <= 11'(Y_MAX);
            idle_q       <= '0;
            play_start_q <= 1'b0;
            start_q      <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_y_q       <= p1_y_d;
            p2_y_q       <= p2_y_d;
            idle_q       <= idle_d;
            play_start_q <= play_start_d;
            start_q      <= start;
            armed_q      <= armed_q | ~start;
        end
    end

    assign mode       = state_q;
    assign demo_en    = (state_q == DEMO);
    assign p1_y       = p1_y_q;
    assign p2_y       = p2_y_q;
    assign play_start = play_start_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with a short idle timeout; inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_paddle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, start, p1_up, p1_dn, p2_up, p2_dn;
    logic [10:0] demo_p1_y, demo_p2_y;
    logic        demo_en, play_start;
    logic [10:0] p1_y, p2_y;
    logic [1:0]  mode;

    int n_cmp = 0;
    int n_err = 0;

    paddle_ctrl #(
        .Y_MIN(62), .Y_MAX(418), .STEP(4), .IDLE_FRAMES(4)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .demo_p1_y(demo_p1_y), .demo_p2_y(demo_p2_y),
        .demo_en(demo_en), .p1_y(p1_y), .p2_y(p2_y),
        .mode(mode), .play_start(play_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 0; start = 0;
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
        demo_p1_y = 11'd500; demo_p2_y = 11'd500;
        step(); step();
        chk("rst_mode", mode, 0);
        chk("rst_demo_en", demo_en, 1);
        chk("rst_p1", p1_y, 62);
        chk("rst_p2", p2_y, 418);
        chk("rst_play_start", play_start, 0);

        rst = 0;
        demo_p1_y = 11'd200; demo_p2_y = 11'd100;
        step();
        chk("demo_track_p1", p1_y, 200);
        chk("demo_track_p2", p2_y, 100);

        demo_p1_y = 11'd150; demo_p2_y = 11'd330; start = 1;
        step();
        chk("start_mode", mode, 1);
        chk("start_demo_en", demo_en, 0);
        chk("start_p1", p1_y, 150);
        chk("start_p2", p2_y, 330);
        chk("start_pulse", play_start, 1);
        step();
        chk("start_pulse_end", play_start, 0);
        for (int i = 0; i < 10; i++) step();
        chk("hold_start_mode", mode, 1);
        start = 0;
        step();

        p1_up = 1; do_tick(); p1_up = 0;
        chk("p1_up_move", p1_y, 146);
        chk("p2_still", p2_y, 330);
        p2_dn = 1; do_tick(); p2_dn = 0;
        chk("p2_dn_move", p2_y, 334);

        demo_p1_y = 11'd64; demo_p2_y = 11'd416;
        do_tick(); do_tick(); do_tick();
        chk("idle3_mode", mode, 1);
        do_tick();
        chk("timeout_mode", mode, 0);
        chk("timeout_demo_en", demo_en, 1);
        chk("timeout_p1_hold", p1_y, 146);
        step();
        chk("retrack_p1", p1_y, 64);
        chk("retrack_p2", p2_y, 416);

        start = 1; step(); start = 0;
        chk("restart_mode", mode, 1);
        chk("restart_pulse", play_start, 1);
        p1_up = 1; p2_dn = 1;
        do_tick();
        chk("clamp_top1", p1_y, 62);
        chk("clamp_bot1", p2_y, 418);
        do_tick();
        chk("clamp_top2", p1_y, 62);
        chk("clamp_bot2", p2_y, 418);
        p1_up = 0; p2_dn = 0;
        p1_dn = 1; do_tick();
        chk("p1_dn_move", p1_y, 66);
        p1_up = 1; do_tick();
        chk("both_btn_hold", p1_y, 66);
        p1_dn = 0;

        start = 1; tick = 1; step(); start = 0; tick = 0;
        chk("pause_mode", mode, 2);
        chk("pause_prio_p1", p1_y, 66);
        do_tick(); do_tick();
        chk("pause_frozen_p1", p1_y, 66);
        p1_up = 0;
        for (int i = 0; i < 5; i++) do_tick();
        chk("pause_no_timeout", mode, 2);
        start = 1; step(); start = 0;
        chk("resume_mode", mode, 1);
        chk("resume_no_pulse", play_start, 0);

        do_tick(); do_tick();
        p2_dn = 1; do_tick(); p2_dn = 0;
        do_tick(); do_tick(); do_tick();
        chk("idle_reset_t6", mode, 1);
        do_tick();
        chk("idle_reset_t7", mode, 0);

        demo_p1_y = 11'd300; demo_p2_y = 11'd200;
        step();
        start = 1; step(); start = 0; step();
        start = 1; step();
        chk("pre_rst_mode", mode, 2);
        chk("pre_rst_p1", p1_y, 300);
        rst = 1;
        #1;
        chk("async_rst_mode", mode, 0);
        chk("async_rst_p1", p1_y, 62);
        chk("async_rst_p2", p2_y, 418);
        chk("async_rst_demo_en", demo_en, 1);
        step();
        rst = 0;
        step(); step();
        chk("held_start_no_press", mode, 0);
        start = 0; step();
        start = 1; step(); start = 0;
        chk("press_after_rst", mode, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
